// File: rtl/tl_pkg.sv
`default_nettype none
// =============================================================================
// Module      : tl_pkg
// Description : TileLink-UL opcodes, host command opcodes and bridge FSM states
// Revision    : 1.0 - initial release
// =============================================================================
package tl_pkg;

    localparam logic [2:0] TL_GET      = 3'd4;
    localparam logic [2:0] TL_PUT_FULL = 3'd0;
    localparam logic [2:0] TL_ACK      = 3'd0;
    localparam logic [2:0] TL_ACK_DATA = 3'd1;

    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    typedef enum logic [2:0] {
        S_OP    = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_REQ   = 3'd3,
        S_RESP  = 3'd4,
        S_SEND  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tl_if.sv
`default_nettype none
// =============================================================================
// Module      : tl_if
// Description : TileLink-UL A/D channel bundle with master and slave views
// Revision    : 1.0 - initial release
// =============================================================================
interface tl_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) ();
    logic                  a_valid;
    logic                  a_ready;
    logic [2:0]            a_opcode;
    logic [2:0]            a_size;
    logic [DATA_W/8-1:0]   a_mask;
    logic [ADDR_W-1:0]     a_address;
    logic [DATA_W-1:0]     a_data;
    logic                  d_valid;
    logic                  d_ready;
    logic [2:0]            d_opcode;
    logic [DATA_W-1:0]     d_data;

    modport master (
        output a_valid, a_opcode, a_size, a_mask, a_address, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_data
    );

    modport slave (
        input  a_valid, a_opcode, a_size, a_mask, a_address, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_data
    );
endinterface
`default_nettype wire

// File: rtl/cmd_bridge.sv
`default_nettype none
// =============================================================================
// Module      : cmd_bridge
// Description : Host byte-stream to TileLink-UL master, one 64-bit access per frame
// Revision    : 1.0 - initial release
// =============================================================================
module cmd_bridge
    import tl_pkg::*;
#(
    parameter int         ADDR_W   = 64,
    parameter int         DATA_W   = 64,
    parameter logic [7:0] ACK_BYTE = 8'hA5,
    parameter logic [7:0] ERR_BYTE = 8'hEE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_empty,
    input  logic [7:0] cmd_dout,
    output logic       cmd_rd_en,
    input  logic       res_almost_full,
    output logic       res_wr_en,
    output logic [7:0] res_din,
    tl_if.master       bus
);

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_byte_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_is_write;
    logic                r_live;
    logic                w_pop;
    logic                w_push;
    logic                w_last_byte;
    logic                w_resp_ok;

    // r_live keeps cmd_rd_en low while reset is held, even if the FIFO is not empty
    assign w_pop = r_live && !cmd_empty &&
                   (r_state == S_OP || r_state == S_ADDR || r_state == S_WDATA);
    assign w_push      = (r_state == S_SEND || r_state == S_ERR) && !res_almost_full;
    assign w_last_byte = (r_byte_cnt == 3'd7);
    assign w_resp_ok   = r_is_write ? (bus.d_opcode == TL_ACK)
                                    : (bus.d_opcode == TL_ACK_DATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_OP;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_OP: begin
                if (w_pop) begin
                    w_next = (cmd_dout == CMD_READ || cmd_dout == CMD_WRITE) ? S_ADDR : S_ERR;
                end
            end
            S_ADDR: begin
                if (w_pop && w_last_byte) begin
                    w_next = r_is_write ? S_WDATA : S_REQ;
                end
            end
            S_WDATA: begin
                if (w_pop && w_last_byte) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.a_ready) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.d_valid) begin
                    w_next = w_resp_ok ? S_SEND : S_ERR;
                end
            end
            S_SEND: begin
                if (w_push && (r_is_write || w_last_byte)) begin
                    w_next = S_OP;
                end
            end
            S_ERR: begin
                if (w_push) begin
                    w_next = S_OP;
                end
            end
            default: w_next = S_OP;
        endcase
    end

    always_comb begin
        bus.a_valid   = 1'b0;
        bus.a_opcode  = 3'd0;
        bus.a_size    = 3'd0;
        bus.a_mask    = '0;
        bus.a_address = '0;
        bus.a_data    = '0;
        bus.d_ready   = 1'b0;
        res_din       = 8'h00;
        case (r_state)
            S_REQ: begin
                bus.a_valid   = 1'b1;
                bus.a_size    = 3'd3;
                bus.a_mask    = '1;
                bus.a_address = r_addr;
                bus.a_opcode  = r_is_write ? TL_PUT_FULL : TL_GET;
                bus.a_data    = r_is_write ? r_wdata : '0;
            end
            S_RESP:  bus.d_ready = 1'b1;
            S_SEND:  res_din = r_is_write ? ACK_BYTE : r_rdata[{r_byte_cnt, 3'b000} +: 8];
            S_ERR:   res_din = ERR_BYTE;
            default: ;
        endcase
    end

    assign cmd_rd_en = w_pop;
    assign res_wr_en = w_push;

    // byte_cnt indexes the incoming address/data bytes and then the outgoing read bytes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live     <= 1'b0;
            r_byte_cnt <= 3'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_is_write <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                S_OP: begin
                    r_byte_cnt <= 3'd0;
                    if (w_pop) begin
                        r_is_write <= (cmd_dout == CMD_WRITE);
                    end
                end
                S_ADDR: begin
                    if (w_pop) begin
                        r_addr[{r_byte_cnt, 3'b000} +: 8] <= cmd_dout;
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                    end
                end
                S_WDATA: begin
                    if (w_pop) begin
                        r_wdata[{r_byte_cnt, 3'b000} +: 8] <= cmd_dout;
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                    end
                end
                S_RESP: begin
                    if (bus.d_valid) begin
                        r_rdata <= bus.d_data;
                    end
                end
                S_SEND: begin
                    if (w_push && !r_is_write) begin
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                    end
                end
                S_ERR:   r_byte_cnt <= 3'd0;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/cmd_bridge.md
Name: cmd_bridge

Overview:
- Byte-stream to TileLink-UL master bridge. It drains host command bytes from the cmd FIFO, issues one 64-bit Get or PutFullData on the tilelink bus, and pushes the response bytes into the res FIFO.
- It sits directly upstream of rom (and any other TL slave). The host stimulus and checker talk to it only through the two FIFOs.

Parameters:
- ADDR_W, 64, TL a_address width
- DATA_W, 64, TL a_data/d_data width; fixed at 8 bytes per beat
- ACK_BYTE, 8'hA5, response byte for a completed write
- ERR_BYTE, 8'hEE, response byte for a bad opcode or unexpected d_opcode

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_empty  in  1  cmd FIFO empty (first-word-fall-through)
- cmd_dout  in  8  cmd FIFO head byte; valid while !cmd_empty
- cmd_rd_en  out  1  pop cmd FIFO head
- res_almost_full  in  1  res FIFO cannot accept more than one byte
- res_wr_en  out  1  push res_din
- res_din  out  8  response byte
- bus  interface  -  tilelink, master side
  - drives a_valid, a_opcode, a_size, a_mask, a_address, a_data, d_ready
  - samples a_ready, d_valid, d_opcode, d_data

Behaviour:
- Reset: async assert on rst_n low; all state clears and the FSM goes to S_OP. Every output is 0 during and after reset until the first action: cmd_rd_en, res_wr_en, res_din, a_valid, a_opcode, a_size, a_mask, a_address, a_data, d_ready.
- Command frame, little-endian:
  - byte0 = opcode: 8'h01 read, 8'h02 write
  - bytes 1-8 = address
  - write only: bytes 9-16 = data
- Byte pop: cmd_rd_en = 1 only in S_OP/S_ADDR/S_WDATA while !cmd_empty. The byte is consumed that same cycle. cmd_rd_en is never asserted while cmd_empty.
- FSM states and transitions:
  - S_OP: on a pop, 01 -> S_ADDR; 02 -> S_ADDR (write flag set); any other value -> S_ERR.
  - S_ADDR: 3-bit byte_cnt shifts each popped byte into addr[8*byte_cnt +: 8]. After the 8th byte, read -> S_REQ and write -> S_WDATA. byte_cnt wraps to 0.
  - S_WDATA: same pattern into wdata, then -> S_REQ.
  - S_REQ: a_valid = 1, a_size = 3, a_mask = 8'hFF, a_address = addr. Read uses a_opcode = 4 (Get) and a_data = 0; write uses a_opcode = 0 (PutFullData) and a_data = wdata. All A fields stay stable until the a_valid & a_ready cycle, then a_valid drops next cycle -> S_RESP.
  - S_RESP: d_ready = 1. On d_valid:
    - read with d_opcode = 1 (AccessAckData): capture d_data -> S_SEND, 8 bytes.
    - write with d_opcode = 0 (AccessAck): -> S_SEND, 1 byte ACK_BYTE.
    - otherwise -> S_ERR.
    - d_ready drops the cycle after the handshake.
  - S_SEND: res_wr_en = 1 when !res_almost_full. res_din = rdata[8*byte_cnt +: 8] (LSB byte first), or ACK_BYTE. Stalls with res_wr_en = 0 while res_almost_full. After the last byte -> S_OP.
  - S_ERR: pushes ERR_BYTE once, with the same almost_full rule, -> S_OP. Any partial frame is discarded.
- Latency:
  - Last cmd byte popped at cycle N -> a_valid high at N+1.
  - a handshake at cycle M -> d_ready high at M+1.
  - d handshake at cycle K -> first res_wr_en at K+1 if the res FIFO has room.
- Outstanding transactions: at most one. No new command byte is popped from S_REQ through S_SEND.
- Empty gaps: cmd_empty mid-frame simply holds the state. There is no timeout.
- Simultaneous d_valid in the a-handshake cycle: ignored, because d_ready is still 0. The slave holds d_valid.
- Reset mid-frame or mid-transaction: state, counters, and A/D outputs clear immediately. No response byte is emitted.

Decomposition:
- Package tl_pkg holds:
  - TL opcode constants: TL_GET = 4, TL_PUT_FULL = 0, TL_ACK = 0, TL_ACK_DATA = 1
  - command opcodes: CMD_READ = 8'h01, CMD_WRITE = 8'h02
  - FSM state enum: S_OP, S_ADDR, S_WDATA, S_REQ, S_RESP, S_SEND, S_ERR
- Single module, no sub-module. The shift/byte-select datapath is small enough to keep inline.

Test Plan:
- Read rom: cmd 01, 00 10 00 00 00 00 00 00 (addr 0x1000), with the slave returning 0x0000_0297_0000_0517. Required: exactly one Get with a_address = 0x1000, a_size = 3, a_mask = FF. res bytes 17 05 00 00 97 02 00 00.
- Write: cmd 02, addr 0x2000, data 0x1122334455667788. Required: one PutFullData with a_data = 0x1122334455667788. res = A5 only.
- Bad opcode 0x7F followed by a valid read frame. Required: res = EE, then the correct 8 read bytes. The read is unaffected.
- Backpressure:
  - a_ready held low 5 cycles: A fields stay stable.
  - res_almost_full high 3 cycles mid-SEND: res_wr_en = 0 for those cycles, and byte order is preserved.
- Cmd FIFO gaps: cmd_empty toggles every other cycle during an address frame. Required: the same a_address as the gap-free case, and cmd_rd_en is never high while cmd_empty.
- Reset asserted while in S_RESP. Required: all outputs 0 immediately, no res byte, and the next full read frame completes normally.
